// File: rtl/mem_pkg.sv
// Shared types and funct3 codes for the load/store responder.
// f3_legal() reports whether a funct3 code is valid for a load or for a store.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Combinational byte-lane steering: store byte enables and replicated write data,
// alignment/funct3 checks, and load extraction with sign/zero extension.
module mem_lane
    import mem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         i_we,
    input  logic [2:0]   i_funct3,
    input  logic [1:0]   i_lane,
    input  logic [N-1:0] i_wdata,
    input  logic [N-1:0] i_rword,
    output logic [3:0]   o_be,
    output logic [N-1:0] o_wdata,
    output logic         o_bad,
    output logic [N-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfwords are only legal at lane 0 or 2, so the byte shift also selects halves.
    assign w_byte = 8'(i_rword >> {i_lane, 3'b000});
    assign w_half = 16'(i_rword >> {i_lane, 3'b000});

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_bad   = !f3_legal(i_we, i_funct3);
        o_rdata = '0;

        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {(N/8){i_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {(N/16){i_wdata[15:0]}};
                if (i_lane[0])
                    o_bad = 1'b1;
            end
            F3_W: begin
                o_be = 4'b1111;
                if (i_lane != 2'b00)
                    o_bad = 1'b1;
            end
            default: ;
        endcase

        case (i_funct3)
            F3_B:    o_rdata = {{(N-8){w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {{(N-8){1'b0}}, w_byte};
            F3_H:    o_rdata = {{(N-16){w_half[15]}}, w_half};
            F3_HU:   o_rdata = {{(N-16){1'b0}}, w_half};
            F3_W:    o_rdata = i_rword;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Load/store memory responder with a fixed number of wait states per access.
// Memory is touched on the edge entering RESP; the response is registered one edge later.
//
// state  | meaning
// IDLE   | req_ready high, waiting for req_valid
// WAIT   | counting down inserted wait states
// RESP   | access done, registered response emitted on the next edge
module mem_responder
    import mem_pkg::*;
#(
    parameter int n     = 32,
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [n-1:0] rsp_rdata,
    output logic         rsp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'((WAIT > 0) ? WAIT - 1 : 0);

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_cnt;
    logic         r_we;
    logic [2:0]   r_f3;
    logic [n-1:0] r_addr;
    logic [n-1:0] r_wdata;
    logic         r_err;
    logic [n-1:0] r_mem [DEPTH];
    logic [n-1:0] r_rword;

    logic         w_accept;
    logic         w_enter_resp;
    logic         w_op_we;
    logic [2:0]   w_op_f3;
    logic [n-1:0] w_op_addr;
    logic [n-1:0] w_op_wdata;
    logic [AW-1:0] w_idx;
    logic         w_oor;
    logic         w_lane_bad;
    logic         w_op_err;
    logic [3:0]   w_be;
    logic [n-1:0] w_wlane;
    logic [n-1:0] w_ld_data;

    // With WAIT=0 the access happens on the accept edge, so use the live request in IDLE.
    assign w_op_we    = (r_state == S_IDLE) ? req_we     : r_we;
    assign w_op_f3    = (r_state == S_IDLE) ? req_funct3 : r_f3;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata  : r_wdata;

    assign w_idx    = w_op_addr[AW+1:2];
    assign w_oor    = ({2'b00, w_op_addr[n-1:2]} >= n'(DEPTH));
    assign w_op_err = w_lane_bad || w_oor;

    mem_lane #(.N(n)) u_lane (
        .i_we     (w_op_we),
        .i_funct3 (w_op_f3),
        .i_lane   (w_op_addr[1:0]),
        .i_wdata  (w_op_wdata),
        .i_rword  (r_rword),
        .o_be     (w_be),
        .o_wdata  (w_wlane),
        .o_bad    (w_lane_bad),
        .o_rdata  (w_ld_data)
    );

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0)
                    w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_next == S_RESP && r_state != S_RESP)
            w_enter_resp = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp)
                r_err <= w_op_err;
            rsp_valid <= (r_state == S_RESP);
            rsp_err   <= (r_state == S_RESP) && r_err;
            rsp_rdata <= (r_state == S_RESP && !r_err && !r_we) ? w_ld_data : '0;
        end
    end

    // No reset on the array so it maps onto block RAM with byte write enables.
    always_ff @(posedge clock) begin
        if (!reset && w_enter_resp) begin
            if (w_op_we && !w_op_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b])
                        r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
            r_rword <= r_mem[w_idx];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT=2 instance for data/latency/error/reset
// scenarios and a WAIT=0 instance for back-to-back throughput.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_reset;
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_responder #(.n(32), .DEPTH(256), .WAIT(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    mem_responder #(.n(32), .DEPTH(256), .WAIT(0)) dut0 (
        .clock      (clock),
        .reset      (b_reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_we     (b_req_we),
        .req_funct3 (b_req_funct3),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .rsp_valid  (b_rsp_valid),
        .rsp_rdata  (b_rsp_rdata),
        .rsp_err    (b_rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT=2 instance; lat counts edges from accept to rsp_valid.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
        int guard;
        @(negedge clock);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 99; rd = 'x; er = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (rsp_valid === 1'b1) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(we, f3, a, wd, rd, er, lat);
        chk({tag, ".lat"}, 32'(lat), 32'd3);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    initial begin
        logic [7:0] rdy_bits, vld_bits;
        int         seen;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = F3_W;
        req_addr = '0; req_wdata = '0;
        b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = F3_W;
        b_req_addr = '0; b_req_wdata = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);

        // Basic word store/load
        run("sw0",  1'b1, F3_W, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        run("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        run("lw10", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte lanes and extension
        run("sb13",  1'b1, F3_B,  32'h13, 32'h0000007F, 32'h0, 1'b0);
        run("lb13",  1'b0, F3_B,  32'h13, 32'h0, 32'h0000007F, 1'b0);
        run("lw10b", 1'b0, F3_W,  32'h10, 32'h0, 32'h7FADBEEF, 1'b0);
        run("sb11",  1'b1, F3_B,  32'h11, 32'h12345680, 32'h0, 1'b0);
        run("lb11",  1'b0, F3_B,  32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
        run("lbu11", 1'b0, F3_BU, 32'h11, 32'h0, 32'h00000080, 1'b0);
        run("lw10c", 1'b0, F3_W,  32'h10, 32'h0, 32'h7FAD80EF, 1'b0);

        // Halfwords
        run("sh22",  1'b1, F3_H,  32'h22, 32'h00008001, 32'h0, 1'b0);
        run("lh22",  1'b0, F3_H,  32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        run("lhu22", 1'b0, F3_HU, 32'h22, 32'h0, 32'h00008001, 1'b0);
        run("lbu23", 1'b0, F3_BU, 32'h23, 32'h0, 32'h00000080, 1'b0);
        run("sh20",  1'b1, F3_H,  32'h20, 32'hFFFF3344, 32'h0, 1'b0);
        run("lw20",  1'b0, F3_W,  32'h20, 32'h0, 32'h80013344, 1'b0);

        // Errors: misaligned, out of range, illegal funct3; memory must be unchanged
        run("lw11.err",   1'b0, F3_W,   32'h11, 32'h0, 32'h0, 1'b1);
        run("sh21.err",   1'b1, F3_H,   32'h21, 32'h0000AAAA, 32'h0, 1'b1);
        run("lw20.keep",  1'b0, F3_W,   32'h20, 32'h0, 32'h80013344, 1'b0);
        run("lw400.err",  1'b0, F3_W,   32'h400, 32'h0, 32'h0, 1'b1);
        run("sw400.err",  1'b1, F3_W,   32'h400, 32'hFFFFFFFF, 32'h0, 1'b1);
        run("lw0.keep",   1'b0, F3_W,   32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        run("sbu10.err",  1'b1, F3_BU,  32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        run("lw10.keep",  1'b0, F3_W,   32'h10, 32'h0, 32'h7FAD80EF, 1'b0);
        run("ld011.err",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);

        // Reset during WAIT drops the store and its response
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h0; req_wdata = 32'h12345678;
        @(posedge clock);
        #1 req_valid = 1'b0; reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        chk("rstw.req_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid === 1'b1) seen++;
            @(posedge clock);
            #1;
        end
        chk("rstw.no_rsp", 32'(seen), 32'd0);
        run("lw0.prior", 1'b0, F3_W, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);

        // WAIT=0 instance: back-to-back stores with req_valid held high
        @(negedge clock);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_funct3 = F3_W;
        b_req_addr = 32'h8; b_req_wdata = 32'h0000A5A5;
        b_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdy_bits[i] = b_req_ready;
            vld_bits[i] = b_rsp_valid;
            @(negedge clock);
        end
        b_req_valid = 1'b0;
        chk("w0.ready_pattern", {24'd0, rdy_bits}, 32'h00000055);
        chk("w0.rsp_pattern",   {24'd0, vld_bits}, 32'h00000054);

        @(negedge clock);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = F3_W; b_req_addr = 32'h8;
        @(posedge clock);
        #1 b_req_valid = 1'b0;
        chk("w0.lw.early", {31'd0, b_rsp_valid}, 32'd0);
        @(posedge clock);
        #1;
        chk("w0.lw.valid", {31'd0, b_rsp_valid}, 32'd1);
        chk("w0.lw.rdata", b_rsp_rdata, 32'h0000A5A5);
        chk("w0.lw.err",   {31'd0, b_rsp_err}, 32'd0);
        @(posedge clock);
        #1;
        chk("w0.lw.pulse", {31'd0, b_rsp_valid}, 32'd0);
        chk("w0.idle.rdata", b_rsp_rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter n, default 32, data and address width.
REQ-002 Parameter DEPTH, default 256, number of n-bit words stored.
REQ-003 Parameter WAIT, default 2, wait-state cycles inserted before each response (range 0..15).
REQ-004 clock  input  1  single clock, all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a load/store request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RV32I access size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-010 req_addr  input  n  byte address.
REQ-011 req_wdata  input  n  store data, right-aligned in bits [7:0] / [15:0] / [31:0].
REQ-012 rsp_valid  output  1  one-cycle pulse, response is valid.
REQ-013 rsp_rdata  output  n  load result, already sign- or zero-extended; 0 for stores and errors.
REQ-014 rsp_err  output  1  qualified by rsp_valid; misaligned, out-of-range, or illegal funct3.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 Handshake: request accepted on a rising edge where req_valid && req_ready; req, we, funct3, addr, and wdata are latched that edge.
REQ-017 Accept with WAIT>0 -> WAIT with counter = WAIT-1; decrement each cycle; counter 0 -> RESP. Accept with WAIT=0 -> RESP directly.
REQ-018 Latency: request accepted at edge T -> rsp_valid high for exactly the cycle after edge T+1+WAIT; RESP -> IDLE unconditionally (no response backpressure).
REQ-019 Throughput: the next request is accepted no earlier than the edge after RESP.
REQ-020 req_valid while not in IDLE is ignored; the initiator holds the request until req_ready.
REQ-021 Word index = addr[n-1:2]; lane = addr[1:0].
REQ-022 Stores commit on the edge entering RESP, updating only the enabled byte lanes: SB = 1 lane at addr[1:0]; SH = lanes {addr[1],0} and {addr[1],1}; SW = all 4 lanes.
REQ-023 Loads are read on the edge entering RESP, the byte/halfword is selected by lane, then extended: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-024 A load to a word written by the immediately preceding store returns the new data.
REQ-025 Error when any of the following holds: halfword with addr[0]=1, word with addr[1:0]!=0, word index >= DEPTH, or funct3 not legal for req_we.
REQ-026 On an error: no memory write, rsp_rdata = 0, rsp_err = 1; latency is unchanged.
REQ-027 Outputs are registered: rsp_valid, rsp_rdata, and rsp_err change only on clock edges.
REQ-028 rsp_rdata and rsp_err hold 0 whenever rsp_valid = 0.

Reset
REQ-029 reset high at an edge -> state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-030 req_ready = 1 in the first cycle after reset is released.
REQ-031 Reset while in WAIT drops the pending request: no store commit and no response.
REQ-032 Memory array contents are not reset.

Structure
REQ-033 Package mem_pkg holds the state enum and named funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-034 Sub-module mem_lane is combinational: it generates byte enables and write-lane data from funct3/addr, and extracts and extends load data.
REQ-035 The memory is an array of DEPTH words with per-byte write enables, inferable as block RAM.

Verification
REQ-036 Scenario 1: WAIT=2, SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 3 cycles after each accept; rdata 0xDEADBEEF; err 0.
REQ-037 Scenario 2: after scenario 1, SB 0x7F @0x13, then LB @0x13 -> rdata 0x0000007F; LW @0x10 -> 0x7FADBEEF.
REQ-038 Scenario 3: SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001; LBU @0x23 -> 0x00000080.
REQ-039 Scenario 4: LW @0x11, SH @0x21, LW @(DEPTH*4) -> each gives rsp_err=1, rdata 0; memory unchanged on readback.
REQ-040 Scenario 5: accept SW 0x12345678 @0x0, assert reset one cycle later -> no rsp_valid; LW @0x0 then returns the prior contents.
REQ-041 Scenario 6: WAIT=0, back-to-back requests with req_valid held high -> req_ready pattern 1,0,1,0; one response per 2 cycles.
